ysyx_22050854_dcache_axi_master: RTL and testbench
==================================================

YSYX_22050854_DCACHE_AXI_MASTER -- requirements
Module: ysyx_22050854_dcache_axi_master

Interface
REQ-001 SHALL have parameter AXI_ID, default 4'd1, the ID driven on arid/awid.
REQ-002 SHALL have clock  input  1  sole clock, rising edge.
REQ-003 SHALL have rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have req_valid/req_ready  in/out  1/1  cache request handshake.
REQ-005 SHALL have req_wr, req_dev  input  1 each  write (1) or read; uncached device access (1) or 16-byte line.
REQ-006 SHALL have req_addr/req_wdata/req_wstrb  input  32/128/8  byte address, line data (beat0 = [63:0]), device byte strobe.
REQ-007 SHALL have resp_valid/resp_rdata/resp_err  output  1/128/1  one-cycle completion pulse, line or device data in [63:0], error flag.
REQ-008 SHALL have AR channel: arvalid out 1, arready in 1, araddr out 32, arid out 4, arlen out 8, arsize out 3, arburst out 2.
REQ-009 SHALL have R channel: rdata in 64, rresp in 2, rvalid in 1, rready out 1, rid in 4, rlast in 1.
REQ-010 SHALL have AW channel (awaddr 32, awvalid, awready in, awid 4, awlen 8, awsize 3, awburst 2), W channel (wdata 64, wvalid, wready in, wstrb 8, wlast), B channel (bresp in 2, bvalid in, bready out, bid in 4).

Function
REQ-011 SHALL use FSM states IDLE, AR, R, AW, W, B, RESP.
REQ-012 SHALL assert req_ready only in IDLE; req_valid&&req_ready latches all req_* and moves to AR (read) or AW (write).
REQ-013 Line access SHALL drive arlen/awlen=1, size=3'd3, burst=INCR (2'b01), address = {req_addr[31:4],4'b0}.
REQ-014 Device access SHALL drive len=0, size=3'd3, burst=FIXED (2'b00), address = req_addr unmodified.
REQ-015 arvalid/awvalid SHALL be held high with stable payload until the respective ready is sampled high, then clear next cycle.
REQ-016 In R, rready SHALL be 1; a beat counts only when rvalid&&rid==AXI_ID; non-matching beats are accepted and discarded.
REQ-017 Counted beat n (0,1) SHALL write rdata into line [64n+63:64n]; FSM leaves R on the last expected beat (beat1 line, beat0 device) regardless of rlast.
REQ-018 In W, beat0 SHALL carry req_wdata[63:0], beat1 [127:64], wstrb=8'hFF for line; device single beat uses req_wstrb; wlast high on the final beat only; wvalid payload stable until wready.
REQ-019 wvalid SHALL NOT assert before aw handshake completes.
REQ-020 In B, bready SHALL be 1; exit to RESP on bvalid&&bid==AXI_ID; other bid ignored.
REQ-021 resp_err SHALL be sticky per transaction: set if any counted rresp or accepted bresp equals 2'b11 (DECERR).
REQ-022 RESP SHALL last exactly one cycle (resp_valid=1) then return to IDLE; best-case read latency req accept -> resp_valid = 2 + arready wait + beat cycles.
REQ-023 rready/bready SHALL be 0 outside R/B; extra beats after completion are not consumed.

Reset
REQ-024 On rst_n low (any time, mid-burst included) SHALL enter IDLE asynchronously; all valid/ready outputs, resp_err, counters, rdata buffer = 0; req_ready = 1 once reset releases.
REQ-025 Partially transferred bursts SHALL be abandoned without completion pulse.

Configuration
REQ-026 Macro YSYX_22050854_AXI_PERF_EN defined SHALL add outputs perf_rd_cnt, perf_wr_cnt, perf_stall_cnt (32 each): completed reads, completed writes, cycles in AR/R/AW/W/B; wrap at 2^32; reset to 0.
REQ-027 Without the macro these ports and counters SHALL not exist; function otherwise identical.

Structure
REQ-028 Package ysyx_22050854_axi_pkg SHALL hold BURST_FIXED/BURST_INCR, SIZE_8B, RESP_OKAY/RESP_DECERR constants and the FSM state enum.
REQ-029 No sub-module; single module with one beat counter.

Verification
REQ-030 Line read 0x8000_0014, slave returns 0x1111.., 0x2222.. -> araddr=0x8000_0010, arlen=1, arburst=01, resp_rdata={0x2222..,0x1111..}, resp_err=0.
REQ-031 Device read 0xA000_03F8 -> araddr=0xA000_03F8, arlen=0, arburst=00, one beat, resp_rdata[63:0]=beat data.
REQ-032 Line write 0x8000_1000 data {B,A} -> beat0 A wlast=0, beat1 B wlast=1, wstrb=FF, resp_valid after bvalid.
REQ-033 Read with interleaved rid=4'd2 beat -> beat discarded, line filled from AXI_ID beats only.
REQ-034 arready held low 5 cycles -> arvalid/araddr stable all 5 cycles; rst_n pulsed during R -> IDLE, no resp_valid, req_ready=1 after release.
REQ-035 rresp=2'b11 on beat1 -> resp_err=1 with resp_valid; with PERF_EN perf_rd_cnt increments by 1.

Source files
------------

// File: rtl/ysyx_22050854_axi_pkg.sv
// Shared AXI4 constants and FSM state encoding for the dcache AXI master.
package ysyx_22050854_axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] SIZE_8B     = 3'd3;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    AR,
    R,
    AW,
    W,
    B,
    RESP
  } state_e;

endpackage

// File: rtl/ysyx_22050854_dcache_axi_master.sv
// AXI4 master for the dcache: 2-beat INCR line fills/writebacks or 1-beat FIXED device accesses.
// Optional performance counters enabled by YSYX_22050854_AXI_PERF_EN.
module ysyx_22050854_dcache_axi_master
  import ysyx_22050854_axi_pkg::*;
#(
  parameter logic [3:0] AXI_ID = 4'd1
) (
  input  logic         clock,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_wr,
  input  logic         req_dev,
  input  logic [31:0]  req_addr,
  input  logic [127:0] req_wdata,
  input  logic [7:0]   req_wstrb,
  output logic         resp_valid,
  output logic [127:0] resp_rdata,
  output logic         resp_err,
`ifdef YSYX_22050854_AXI_PERF_EN
  output logic [31:0]  perf_rd_cnt,
  output logic [31:0]  perf_wr_cnt,
  output logic [31:0]  perf_stall_cnt,
`endif
  output logic         arvalid,
  input  logic         arready,
  output logic [31:0]  araddr,
  output logic [3:0]   arid,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  input  logic [63:0]  rdata,
  input  logic [1:0]   rresp,
  input  logic         rvalid,
  output logic         rready,
  input  logic [3:0]   rid,
  input  logic         rlast,
  output logic [31:0]  awaddr,
  output logic         awvalid,
  input  logic         awready,
  output logic [3:0]   awid,
  output logic [7:0]   awlen,
  output logic [2:0]   awsize,
  output logic [1:0]   awburst,
  output logic [63:0]  wdata,
  output logic         wvalid,
  input  logic         wready,
  output logic [7:0]   wstrb,
  output logic         wlast,
  input  logic [1:0]   bresp,
  input  logic         bvalid,
  output logic         bready,
  input  logic [3:0]   bid
);

  state_e       r_state;
  logic         r_wr;
  logic         r_dev;
  logic [31:0]  r_addr;
  logic [127:0] r_wdata;
  logic [7:0]   r_wstrb;
  logic [127:0] r_line;
  logic         r_err;
  logic         r_cnt;
  logic         r_arvalid;
  logic         r_awvalid;
  logic         r_wvalid;

  // Burst length is fixed by the expected beat count, so rlast is intentionally ignored.
  logic w_unused_rlast;
  assign w_unused_rlast = rlast;

  assign req_ready  = (r_state == IDLE);
  assign resp_valid = (r_state == RESP);
  assign resp_rdata = r_line;
  assign resp_err   = r_err;

  assign arvalid = r_arvalid;
  assign araddr  = r_addr;
  assign arid    = AXI_ID;
  assign arlen   = r_dev ? 8'd0 : 8'd1;
  assign arsize  = SIZE_8B;
  assign arburst = r_dev ? BURST_FIXED : BURST_INCR;
  assign rready  = (r_state == R);

  assign awvalid = r_awvalid;
  assign awaddr  = r_addr;
  assign awid    = AXI_ID;
  assign awlen   = r_dev ? 8'd0 : 8'd1;
  assign awsize  = SIZE_8B;
  assign awburst = r_dev ? BURST_FIXED : BURST_INCR;

  assign wvalid = r_wvalid;
  assign wdata  = r_cnt ? r_wdata[127:64] : r_wdata[63:0];
  assign wstrb  = r_dev ? r_wstrb : 8'hFF;
  assign wlast  = r_dev | r_cnt;
  assign bready = (r_state == B);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_wr      <= 1'b0;
      r_dev     <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_line    <= '0;
      r_err     <= 1'b0;
      r_cnt     <= 1'b0;
      r_arvalid <= 1'b0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_wr    <= req_wr;
            r_dev   <= req_dev;
            r_addr  <= req_dev ? req_addr : {req_addr[31:4], 4'b0};
            r_wdata <= req_wdata;
            r_wstrb <= req_wstrb;
            r_err   <= 1'b0;
            r_cnt   <= 1'b0;
            if (req_wr) begin
              r_awvalid <= 1'b1;
              r_state   <= AW;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= AR;
            end
          end
        end
        AR: begin
          if (arready) begin
            r_arvalid <= 1'b0;
            r_state   <= R;
          end
        end
        R: begin
          // Beats tagged with a foreign ID are accepted but leave no trace.
          if (rvalid && (rid == AXI_ID)) begin
            if (r_cnt) r_line[127:64] <= rdata;
            else       r_line[63:0]   <= rdata;
            if (rresp == RESP_DECERR) r_err <= 1'b1;
            if (r_cnt || r_dev) r_state <= RESP;
            else                r_cnt   <= 1'b1;
          end
        end
        AW: begin
          if (awready) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b1;
            r_state   <= W;
          end
        end
        W: begin
          if (wready) begin
            if (wlast) begin
              r_wvalid <= 1'b0;
              r_state  <= B;
            end else begin
              r_cnt <= 1'b1;
            end
          end
        end
        B: begin
          if (bvalid && (bid == AXI_ID)) begin
            if (bresp == RESP_DECERR) r_err <= 1'b1;
            r_state <= RESP;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef YSYX_22050854_AXI_PERF_EN
  logic [31:0] r_perf_rd;
  logic [31:0] r_perf_wr;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_rd    <= '0;
      r_perf_wr    <= '0;
      r_perf_stall <= '0;
    end else begin
      if (r_state == RESP && !r_wr) r_perf_rd <= r_perf_rd + 32'd1;
      if (r_state == RESP &&  r_wr) r_perf_wr <= r_perf_wr + 32'd1;
      if (r_state inside {AR, R, AW, W, B}) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_rd_cnt    = r_perf_rd;
  assign perf_wr_cnt    = r_perf_wr;
  assign perf_stall_cnt = r_perf_stall;
`endif

endmodule

// File: tb/tb_ysyx_22050854_dcache_axi_master.sv
// Scoreboard bench for the dcache AXI master: the bench acts as requester and AXI slave,
// pushes expected completions into a queue, and a monitor pops them on resp_valid.
`timescale 1ns/1ps
module tb_ysyx_22050854_dcache_axi_master;

  localparam logic [3:0] ID = 4'd1;

  logic         clock = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid, req_ready, req_wr, req_dev;
  logic [31:0]  req_addr;
  logic [127:0] req_wdata;
  logic [7:0]   req_wstrb;
  logic         resp_valid, resp_err;
  logic [127:0] resp_rdata;
  logic         arvalid, arready;
  logic [31:0]  araddr;
  logic [3:0]   arid;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic [63:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid, rready, rlast;
  logic [3:0]   rid;
  logic [31:0]  awaddr;
  logic         awvalid, awready;
  logic [3:0]   awid;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic [63:0]  wdata;
  logic         wvalid, wready, wlast;
  logic [7:0]   wstrb;
  logic [1:0]   bresp;
  logic         bvalid, bready;
  logic [3:0]   bid;
`ifdef YSYX_22050854_AXI_PERF_EN
  logic [31:0]  perf_rd_cnt, perf_wr_cnt, perf_stall_cnt;
  int           exp_rd = 0;
  int           exp_wr = 0;
`endif

  always #5 clock = ~clock;

  ysyx_22050854_dcache_axi_master #(.AXI_ID(ID)) u_dut (
    .clock(clock), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr), .req_dev(req_dev),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
`ifdef YSYX_22050854_AXI_PERF_EN
    .perf_rd_cnt(perf_rd_cnt), .perf_wr_cnt(perf_wr_cnt), .perf_stall_cnt(perf_stall_cnt),
`endif
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready), .rid(rid), .rlast(rlast),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready), .awid(awid), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .wdata(wdata), .wvalid(wvalid), .wready(wready), .wstrb(wstrb), .wlast(wlast),
    .bresp(bresp), .bvalid(bvalid), .bready(bready), .bid(bid)
  );

  typedef struct {
    bit           wr;
    bit           cmp_lo;
    bit           cmp_hi;
    logic [127:0] data;
    bit           err;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [1:0] rnd_resp();
    case ($urandom_range(0, 3))
      0, 1:    return 2'b00;
      2:       return 2'b10;
      default: return 2'b11;
    endcase
  endfunction

  // Monitor: every completion pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (resp_valid === 1'b1) begin
        if (sb.size() == 0) begin
          chk("spurious_resp", 128'(resp_valid), 128'(0));
        end else begin
          e = sb.pop_front();
          if (e.cmp_lo) chk("rdata_lo", 128'(resp_rdata[63:0]), 128'(e.data[63:0]));
          if (e.cmp_hi) chk("rdata_hi", 128'(resp_rdata[127:64]), 128'(e.data[127:64]));
          chk("resp_err", 128'(resp_err), 128'(e.err));
`ifdef YSYX_22050854_AXI_PERF_EN
          if (e.wr) exp_wr++;
          else      exp_rd++;
`endif
        end
      end
    end
  end

  task automatic do_read(input logic dev, input logic [31:0] addr, input logic [63:0] b0,
                         input logic [63:0] b1, input logic [1:0] rr0, input logic [1:0] rr1,
                         input int unsigned ar_wait, input bit rogue, input bit extra);
    logic [31:0] ea;
    int          nb;
    exp_t        e;
    ea       = dev ? addr : {addr[31:4], 4'h0};
    nb       = dev ? 1 : 2;
    e.wr     = 1'b0;
    e.cmp_lo = 1'b1;
    e.cmp_hi = !dev;
    e.data   = {b1, b0};
    e.err    = (rr0 == 2'b11) || (!dev && rr1 == 2'b11);
    sb.push_back(e);
    req_valid = 1'b1; req_wr = 1'b0; req_dev = dev; req_addr = addr;
    chk("req_ready", 128'(req_ready), 128'(1));
    step();
    req_valid = 1'b0; req_addr = $urandom;
    for (int i = 0; i < int'(ar_wait); i++) begin
      chk("ar_hold", 128'({arvalid, araddr}), 128'({1'b1, ea}));
      step();
    end
    chk("ar_payload", 128'({arvalid, araddr, arid, arlen, arsize, arburst}),
        128'({1'b1, ea, ID, (dev ? 8'd0 : 8'd1), 3'd3, (dev ? 2'b00 : 2'b01)}));
    arready = 1'b1;
    step();
    arready = 1'b0;
    chk("ar_clear", 128'(arvalid), 128'(0));
    for (int n = 0; n < nb; n++) begin
      if (rogue) begin
        rvalid = 1'b1; rid = 4'd2; rdata = {$urandom, $urandom}; rresp = 2'b11; rlast = 1'b1;
        chk("rready_rogue", 128'(rready), 128'(1));
        step();
      end
      rvalid = 1'b1; rid = ID; rdata = (n == 1) ? b1 : b0; rresp = (n == 1) ? rr1 : rr0;
      rlast = (n == nb - 1);
      chk("rready", 128'(rready), 128'(1));
      step();
    end
    rvalid = 1'b0;
    chk("rd_resp_timing", 128'(resp_valid), 128'(1));
    if (extra) begin
      rvalid = 1'b1; rid = ID; rdata = {$urandom, $urandom}; rresp = 2'b00;
      chk("rready_after", 128'(rready), 128'(0));
    end
    step();
    rvalid = 1'b0;
  endtask

  task automatic do_write(input logic dev, input logic [31:0] addr, input logic [127:0] wd,
                          input logic [7:0] ws, input logic [1:0] br, input int unsigned aw_wait,
                          input int unsigned w_wait, input bit rogue);
    logic [31:0] ea;
    logic [63:0] ed;
    logic [7:0]  es;
    int          nb;
    exp_t        e;
    ea       = dev ? addr : {addr[31:4], 4'h0};
    es       = dev ? ws : 8'hFF;
    nb       = dev ? 1 : 2;
    e.wr     = 1'b1;
    e.cmp_lo = 1'b0;
    e.cmp_hi = 1'b0;
    e.data   = '0;
    e.err    = (br == 2'b11);
    sb.push_back(e);
    req_valid = 1'b1; req_wr = 1'b1; req_dev = dev; req_addr = addr; req_wdata = wd; req_wstrb = ws;
    chk("req_ready", 128'(req_ready), 128'(1));
    step();
    req_valid = 1'b0; req_addr = $urandom;
    req_wdata = {$urandom, $urandom, $urandom, $urandom}; req_wstrb = 8'($urandom);
    for (int i = 0; i < int'(aw_wait); i++) begin
      chk("aw_hold", 128'({awvalid, awaddr, wvalid}), 128'({1'b1, ea, 1'b0}));
      step();
    end
    chk("aw_payload", 128'({awvalid, awaddr, awid, awlen, awsize, awburst, wvalid}),
        128'({1'b1, ea, ID, (dev ? 8'd0 : 8'd1), 3'd3, (dev ? 2'b00 : 2'b01), 1'b0}));
    awready = 1'b1;
    step();
    awready = 1'b0;
    chk("aw_clear", 128'(awvalid), 128'(0));
    for (int n = 0; n < nb; n++) begin
      ed = (n == 1) ? wd[127:64] : wd[63:0];
      for (int i = 0; i < int'(w_wait); i++) begin
        chk("w_hold", 128'({wvalid, wdata, wstrb, wlast}), 128'({1'b1, ed, es, (n == nb - 1)}));
        step();
      end
      chk("w_beat", 128'({wvalid, wdata, wstrb, wlast}), 128'({1'b1, ed, es, (n == nb - 1)}));
      wready = 1'b1;
      step();
      wready = 1'b0;
    end
    chk("w_clear", 128'(wvalid), 128'(0));
    if (rogue) begin
      bvalid = 1'b1; bid = 4'd2; bresp = 2'b11;
      chk("bready_rogue", 128'(bready), 128'(1));
      step();
    end
    bvalid = 1'b1; bid = ID; bresp = br;
    chk("bready", 128'(bready), 128'(1));
    step();
    bvalid = 1'b0;
    chk("wr_resp_timing", 128'(resp_valid), 128'(1));
    step();
  endtask

  // Start a line read, deliver one beat, then yank reset asynchronously mid-burst.
  task automatic do_reset_mid_read();
    req_valid = 1'b1; req_wr = 1'b0; req_dev = 1'b0; req_addr = 32'h8000_2000;
    step();
    req_valid = 1'b0; arready = 1'b1;
    step();
    arready = 1'b0;
    rvalid = 1'b1; rid = ID; rdata = 64'hDEAD_BEEF_0000_0001; rresp = 2'b00; rlast = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_ctrl", 128'({req_ready, rready, arvalid, resp_valid, resp_err}), 128'(5'b10000));
    chk("rst_rdata", resp_rdata, 128'(0));
    step();
    rvalid = 1'b0;
    rst_n  = 1'b1;
`ifdef YSYX_22050854_AXI_PERF_EN
    exp_rd = 0;
    exp_wr = 0;
`endif
    step();
    chk("rst_release", 128'({req_ready, rready, resp_valid}), 128'(3'b100));
  endtask

  initial begin
    logic        wr, dev;
    logic [31:0] a;
    logic [1:0]  r0, r1;
    req_valid = 0; req_wr = 0; req_dev = 0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    arready = 0; rdata = '0; rresp = '0; rvalid = 0; rid = '0; rlast = 0;
    awready = 0; wready = 0; bresp = '0; bvalid = 0; bid = '0;
    repeat (3) step();
    chk("reset_ctrl", 128'({req_ready, arvalid, awvalid, wvalid, rready, bready, resp_valid, resp_err}),
        128'(8'b1000_0000));
    chk("reset_rdata", resp_rdata, 128'(0));
    rst_n = 1'b1;
    step();
    chk("post_reset_ready", 128'(req_ready), 128'(1));

    do_read(1'b0, 32'h8000_0014, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 2'b00, 2'b00, 0, 0, 0);
    do_read(1'b1, 32'hA000_03F8, 64'h0123_4567_89AB_CDEF, 64'h0, 2'b00, 2'b00, 1, 0, 1);
    do_write(1'b0, 32'h8000_1000, {64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA}, 8'h00, 2'b00, 0, 0, 0);
    do_read(1'b0, 32'h8000_0040, 64'h3333_0000_3333_0000, 64'h4444_0000_4444_0000, 2'b00, 2'b00, 0, 1, 0);
    do_read(1'b0, 32'h8000_008C, 64'h5555_5555_0000_0005, 64'h6666_6666_0000_0006, 2'b00, 2'b00, 5, 0, 0);
    do_reset_mid_read();
    do_read(1'b0, 32'h8000_0100, 64'h7777_7777_7777_7777, 64'h8888_8888_8888_8888, 2'b00, 2'b11, 0, 0, 0);
    do_write(1'b1, 32'hA000_0013, {64'hFFFF_0000_FFFF_0000, 64'h1234_5678_9ABC_DEF0}, 8'h0F, 2'b11, 2, 1, 1);

    for (int k = 0; k < 40; k++) begin
      wr  = 1'($urandom_range(0, 1));
      dev = 1'($urandom_range(0, 1));
      a   = $urandom;
      r0  = rnd_resp();
      r1  = rnd_resp();
      if (wr)
        do_write(dev, a, {$urandom, $urandom, $urandom, $urandom}, 8'($urandom), r0,
                 $urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      else
        do_read(dev, a, {$urandom, $urandom}, {$urandom, $urandom}, r0, r1,
                $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    step();
    chk("sb_drain", 128'(sb.size()), 128'(0));
`ifdef YSYX_22050854_AXI_PERF_EN
    chk("perf_rd", 128'(perf_rd_cnt), 128'(exp_rd));
    chk("perf_wr", 128'(perf_wr_cnt), 128'(exp_wr));
    chk("perf_stall_live", 128'(perf_stall_cnt != 32'd0), 128'(1));
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
